aes_round_ctrl: RTL
===================

Name: aes_round_ctrl

Overview:
Iterative AES-128 encryption sequencer. It time-multiplexes one external single-round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) across all 10 rounds. It does three other jobs itself:
- performs the initial AddRoundKey;
- generates round keys on the fly, with no stored key schedule;
- provides valid/ready handshakes toward the block producer and the ciphertext consumer.

Parameters:
- RND_LAT, 0: register stages inside the external round datapath. Legal values 0..3. Each round occupies RND_LAT+1 cycles.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  plaintext/key pair available
- in_ready  out  1  controller can accept a block
- plaintext  in  128  input block, byte 0 in bits [127:120]
- key  in  128  cipher key, same byte order
- out_valid  out  1  ciphertext available
- out_ready  in  1  consumer accepts ciphertext
- ciphertext  out  128  result block
- busy  out  1  high from accept until ciphertext handed off
- round_idx  out  4  current round number, 0 when idle (debug)
- rnd_in  out  128  state presented to round datapath
- rnd_key  out  128  round key presented to round datapath
- rnd_final  out  1  high in round 10; datapath bypasses MixColumns
- rnd_out  in  128  round datapath result

Behaviour:
Reset:
- FSM enters IDLE.
- in_ready=1. out_valid=0, busy=0, round_idx=0, rnd_final=0.
- ciphertext, rnd_in, rnd_key and the internal state/key registers all clear to 0.
- Reset mid-operation discards the block in flight. No output is produced for it.

FSM states are IDLE, RUN, DONE.
- in_ready = (IDLE) or (DONE and out_ready).
- Accept = in_valid and in_ready on a rising edge.
- in_valid while in_ready=0 is ignored. Nothing is latched.

On accept:
- state_reg <= plaintext XOR key; key_reg <= key.
- round_idx <= 1, wait_cnt <= 0, FSM -> RUN, busy=1.

In RUN:
- rnd_in = state_reg.
- rnd_key = key_step(key_reg, RCON[round_idx]), combinational.
- rnd_final = (round_idx==10).
- Inputs are held stable for RND_LAT+1 cycles. wait_cnt counts 0..RND_LAT.
- On the edge where wait_cnt==RND_LAT:
  - state_reg <= rnd_out, key_reg <= rnd_key, wait_cnt <= 0.
  - If round_idx==10: ciphertext <= rnd_out, FSM -> DONE, round_idx <= 0.
  - Otherwise round_idx increments.

key_step (FIPS-197 key expansion, one round):
- w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}.
- w1' = w1 ^ w0', w2' = w2 ^ w1', w3' = w3 ^ w2'.
- RCON for rounds 1..10 = 01,02,04,08,10,20,40,80,1b,36.

In DONE:
- out_valid=1. ciphertext is held stable until out_ready.
- out_ready=1 with in_valid=0: FSM -> IDLE, out_valid=0, busy=0 on the next cycle.
- out_ready=1 with in_valid=1 (simultaneous handoff and accept): the new block loads as on accept. FSM -> RUN, out_valid drops, busy stays 1.

Latency:
- Accept edge to first cycle with out_valid=1 is 10*(RND_LAT+1) cycles.
- Throughput is one block per 10*(RND_LAT+1)+1 cycles when out_ready is held high.

Other rules:
- All XORs are 128-bit. There is no arithmetic overflow.
- round_idx never exceeds 10.

Decomposition:
- Package aes_pkg:
  - FSM state enum;
  - RCON table, 10x8 bits;
  - S-box function, shared with the sub_bytes stage;
  - AES_ROUNDS=10.
- Sub-module aes_key_step: combinational, inputs 128-bit key and 8-bit rcon, output 128-bit next key. Instantiated once in aes_round_ctrl.
- The round datapath is external and connected via the rnd_* ports. The bench instantiates the team's existing round datapath behind these ports.

Test Plan:
1. FIPS-197 Appendix C.1 vector: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, RND_LAT=0.
   -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a. out_valid first high exactly 10 cycles after the accept edge.
2. Appendix B vector: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, RND_LAT=2.
   -> ciphertext 3925841d02dc09fbdc118597196a0b32 after 30 cycles. rnd_key in round 1 = a0fafe1788542cb123a339392a6c7605.
   -> rnd_final high only during round 10.
3. Backpressure: out_ready=0 for 20 cycles after done.
   -> out_valid and ciphertext stable throughout. in_ready=0. A new in_valid is ignored, with no state change.
4. Back-to-back: second block with in_valid held high, out_ready=1.
   -> handoff of block 1 and accept of block 2 occur on the same edge. Block 2's result is correct. busy never drops.
5. Reset asserted in round 5 for 1 cycle.
   -> next cycle IDLE: in_ready=1, out_valid=0, round_idx=0. A subsequent fresh block gives the correct result.
6. in_valid pulses while in RUN.
   -> not accepted. The in-flight result is unchanged.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, FSM state type and S-box lookup
package aes_pkg;

   localparam int AES_ROUNDS = 10;

   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

   localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   // byte 0x00 sits in the top 8 bits, byte 0xff in the bottom 8 bits
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] a);
      return SBOX[{~a, 3'b000} +: 8];
   endfunction

   // rounds outside 1..10 get a zero constant so idle cycles stay benign
   function automatic logic [7:0] rcon_of(input logic [3:0] r);
      return (r >= 4'd1 && r <= 4'd10) ? RCON[r - 4'd1] : 8'h00;
   endfunction

endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: one round of the AES-128 key expansion, purely combinational
module aes_key_step
   import aes_pkg::*;
(
   input  logic [127:0] key,
   input  logic [7:0]   rcon,
   output logic [127:0] next_key
);

   logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;

   assign {w0, w1, w2, w3} = key;
   assign t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon, 24'h0};
   assign n0 = w0 ^ t;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;
   assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 sequencer driving an external single-round datapath
module aes_round_ctrl
   import aes_pkg::*;
#(
   parameter int RND_LAT = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] plaintext,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] ciphertext,
   output logic         busy,
   output logic [3:0]   round_idx,
   output logic [127:0] rnd_in,
   output logic [127:0] rnd_key,
   output logic         rnd_final,
   input  logic [127:0] rnd_out
);

   fsm_t         fsm;
   logic [127:0] state_reg, key_reg, next_key;
   logic [7:0]   rcon_cur;
   logic [1:0]   wait_cnt;
   logic         accept, last_cycle, is_run;

   assign rcon_cur = rcon_of(round_idx);

   aes_key_step u_key_step (
      .key      (key_reg),
      .rcon     (rcon_cur),
      .next_key (next_key)
   );

   assign is_run     = (fsm == RUN);
   assign in_ready   = (fsm == IDLE) || (fsm == DONE && out_ready);
   assign accept     = in_valid && in_ready;
   assign last_cycle = is_run && (wait_cnt == 2'(RND_LAT));
   assign out_valid  = (fsm == DONE);
   assign busy       = (fsm != IDLE);
   assign rnd_final  = is_run && (round_idx == 4'(AES_ROUNDS));
   // the datapath sees zeros outside RUN so stale keys never leak out
   assign rnd_in     = is_run ? state_reg : '0;
   assign rnd_key    = is_run ? next_key : '0;

   // sequencer: load on accept, hold each round RND_LAT+1 cycles, park in DONE until handoff
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm        <= IDLE;
         state_reg  <= '0;
         key_reg    <= '0;
         ciphertext <= '0;
         round_idx  <= '0;
         wait_cnt   <= '0;
      end else if (accept) begin
         fsm       <= RUN;
         state_reg <= plaintext ^ key;
         key_reg   <= key;
         round_idx <= 4'd1;
         wait_cnt  <= '0;
      end else if (last_cycle) begin
         state_reg <= rnd_out;
         key_reg   <= next_key;
         wait_cnt  <= '0;
         if (round_idx == 4'(AES_ROUNDS)) begin
            ciphertext <= rnd_out;
            fsm        <= DONE;
            round_idx  <= '0;
         end else begin
            round_idx <= round_idx + 4'd1;
         end
      end else if (is_run) begin
         wait_cnt <= wait_cnt + 2'd1;
      end else if (fsm == DONE && out_ready) begin
         fsm <= IDLE;
      end
   end

endmodule
